// File: rtl/ppu_types_pkg.sv
// Shared PPU types: register file view, pixel colour, background fetcher
// states and VRAM base addresses for the tile map and tile data areas.
package ppu_types_pkg;

    localparam int unsigned FIFO_DEPTH = 8;

    typedef logic [1:0] gb_color_t;

    typedef struct packed {
        logic [7:0] lcdc;
        logic [7:0] scx;
        logic [7:0] scy;
        logic [7:0] ly;
    } ppu_regs_t;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        TILE_NUM = 3'd1,
        DATA_LO  = 3'd2,
        DATA_HI  = 3'd3,
        PUSH     = 3'd4
    } fetch_state_t;

    localparam logic [15:0] MAP_BASE_LO        = 16'h9800;
    localparam logic [15:0] MAP_BASE_HI        = 16'h9C00;
    localparam logic [15:0] TILE_BASE_UNSIGNED = 16'h8000;
    localparam logic [15:0] TILE_BASE_SIGNED   = 16'h9000;

endpackage

// File: rtl/ppu_util_pkg.sv
// Pure helpers for the PPU. bg_fetch_addr returns the VRAM byte address the
// background fetcher reads in a given fetch state (map entry, tile low byte
// or tile high byte). All arithmetic is 16-bit and wraps.
package ppu_util_pkg;

    import ppu_types_pkg::*;

    function automatic logic [15:0] bg_fetch_addr(
        input fetch_state_t st,
        input ppu_regs_t    regs,
        input logic [7:0]   tile_num,
        input logic [15:0]  fetch_x,
        input logic [15:0]  map_width
    );
        logic [7:0]  y;
        logic [15:0] col;
        logic [15:0] base;
        logic [15:0] result;
        y = regs.ly + regs.scy;
        col = (16'(regs.scx[7:3]) + fetch_x) % map_width;
        if (st == TILE_NUM) begin
            base   = regs.lcdc[3] ? MAP_BASE_HI : MAP_BASE_LO;
            result = base + {6'b0, y[7:3], 5'b0} + col;
        end else begin
            // lcdc[4] selects unsigned 0x8000 indexing vs signed 0x9000 indexing
            if (regs.lcdc[4]) begin
                base = TILE_BASE_UNSIGNED + {4'b0, tile_num, 4'b0};
            end else begin
                base = TILE_BASE_SIGNED + {{4{tile_num[7]}}, tile_num, 4'b0};
            end
            result = base + {12'b0, y[2:0], (st == DATA_HI)};
        end
        return result;
    endfunction

endpackage

// File: rtl/bg_fetcher.sv
// Background tile fetcher: reads map entry, tile low byte and tile high byte
// from VRAM (2 dots each), then pushes 8 pixels into an empty pixel FIFO.
// Ports:
//   clk, reset_n     PPU dot clock, asynchronous active-low reset
//   active           high during pixel transfer; low forces IDLE
//   regs             lcdc/scx/scy/ly, sampled combinationally every dot
//   read_req/addr    VRAM read request and byte address
//   rdata            VRAM data, valid the dot after read_req
//   write_en         one-dot push of write_data (index 0 = leftmost pixel)
//   full/empty       pixel FIFO status
//   stall_cycles     (only with PPU_FETCH_PERF_EN) saturating count of dots
//                    spent waiting in PUSH; cleared on reset and active rising
module bg_fetcher
    import ppu_types_pkg::*;
    import ppu_util_pkg::*;
#(
    parameter int unsigned MAP_WIDTH_TILES = 32
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       active,
    input  ppu_regs_t                  regs,
    output logic                       read_req,
    output logic [15:0]                addr,
    input  logic [7:0]                 rdata,
    output logic                       write_en,
    output gb_color_t [FIFO_DEPTH-1:0] write_data,
    input  logic                       full,
    input  logic                       empty
`ifdef PPU_FETCH_PERF_EN
    ,
    output logic [15:0]                stall_cycles
`endif
);

    localparam int unsigned    FX_W    = (MAP_WIDTH_TILES > 1) ? $clog2(MAP_WIDTH_TILES) : 1;
    localparam logic [FX_W-1:0] FX_LAST = FX_W'(MAP_WIDTH_TILES - 1);
    localparam logic [15:0]    MAP_W16 = 16'(MAP_WIDTH_TILES);

    fetch_state_t    state, state_d;
    logic            phase, phase_d;
    logic [FX_W-1:0] fetch_x, fetch_x_d;
    logic [7:0]      tile_num, tile_num_d;
    logic [7:0]      lo, lo_d;
    logic [7:0]      hi, hi_d;
    logic            in_fetch;
    logic            push_ok;

    // lcdc bits and fine scroll bits this block has no use for
    logic unused_regs;
    assign unused_regs = ^{regs.lcdc[7:5], regs.lcdc[2:1], regs.scx[2:0]};

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            phase    <= 1'b0;
            fetch_x  <= '0;
            tile_num <= '0;
            lo       <= '0;
            hi       <= '0;
        end else begin
            state    <= state_d;
            phase    <= phase_d;
            fetch_x  <= fetch_x_d;
            tile_num <= tile_num_d;
            lo       <= lo_d;
            hi       <= hi_d;
        end
    end

    // Next state and VRAM/FIFO handshake; phase 0 requests, phase 1 latches
    always_comb begin
        state_d    = state;
        phase_d    = phase;
        fetch_x_d  = fetch_x;
        tile_num_d = tile_num;
        lo_d       = lo;
        hi_d       = hi;

        in_fetch = (state == TILE_NUM) || (state == DATA_LO) || (state == DATA_HI);
        push_ok  = active && (state == PUSH) && empty && !full;
        read_req = active && in_fetch && !phase;
        write_en = push_ok;
        addr     = read_req ? bg_fetch_addr(state, regs, tile_num, 16'(fetch_x), MAP_W16) : 16'h0000;

        if (!active) begin
            state_d   = IDLE;
            phase_d   = 1'b0;
            fetch_x_d = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_d = TILE_NUM;
                    phase_d = 1'b0;
                end
                TILE_NUM: begin
                    phase_d = ~phase;
                    if (phase) begin
                        tile_num_d = rdata;
                        state_d    = DATA_LO;
                    end
                end
                DATA_LO: begin
                    phase_d = ~phase;
                    if (phase) begin
                        lo_d    = rdata;
                        state_d = DATA_HI;
                    end
                end
                DATA_HI: begin
                    phase_d = ~phase;
                    if (phase) begin
                        hi_d    = rdata;
                        state_d = PUSH;
                    end
                end
                PUSH: begin
                    phase_d = 1'b0;
                    if (push_ok) begin
                        fetch_x_d = (fetch_x == FX_LAST) ? '0 : fetch_x + 1'b1;
                        state_d   = TILE_NUM;
                    end
                end
                default: begin
                    state_d = IDLE;
                    phase_d = 1'b0;
                end
            endcase
        end
    end

    // Pixel i takes bit (7-i) of each plane; BG disabled forces colour 0
    for (genvar g = 0; g < FIFO_DEPTH; g++) begin : g_pix
        assign write_data[g] = regs.lcdc[0] ? {hi[FIFO_DEPTH-1-g], lo[FIFO_DEPTH-1-g]} : 2'b00;
    end

`ifdef PPU_FETCH_PERF_EN
    logic active_q;

    // Saturating count of dots stuck in PUSH; restarts with each active window
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active_q     <= 1'b0;
            stall_cycles <= '0;
        end else begin
            active_q <= active;
            if (active && !active_q) begin
                stall_cycles <= '0;
            end else if (active && (state == PUSH) && !push_ok && (stall_cycles != 16'hFFFF)) begin
                stall_cycles <= stall_cycles + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_bg_fetcher.sv
// Bench for bg_fetcher: the driver pushes each expected VRAM read / FIFO
// push (with its dot number) into a queue at the dot it should happen; a
// monitor pops and compares whenever read_req or write_en is seen.
module tb_bg_fetcher;

    import ppu_types_pkg::*;

    localparam int MAP_W = 32;

    logic                       clk;
    logic                       reset_n;
    logic                       active;
    ppu_regs_t                  regs;
    logic                       read_req;
    logic [15:0]                addr;
    logic [7:0]                 rdata;
    logic                       write_en;
    gb_color_t [FIFO_DEPTH-1:0] write_data;
    logic                       full;
    logic                       empty;
`ifdef PPU_FETCH_PERF_EN
    logic [15:0]                stall_cycles;
`endif

    logic [7:0] vram [0:65535];

    typedef struct {
        bit          is_push;
        int unsigned cyc;
        logic [15:0] val;
    } exp_t;

    exp_t        q[$];
    int unsigned cyc;
    int          n_checks;
    int          n_fail;

    bg_fetcher #(.MAP_WIDTH_TILES(MAP_W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .active     (active),
        .regs       (regs),
        .read_req   (read_req),
        .addr       (addr),
        .rdata      (rdata),
        .write_en   (write_en),
        .write_data (write_data),
        .full       (full),
        .empty      (empty)
`ifdef PPU_FETCH_PERF_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // VRAM: data for the address presented this dot appears the next dot
    always @(posedge clk) rdata <= vram[addr];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (dot %0d)", name, got, exp, cyc);
        end
    endtask

    // Reference: address from the register values and tile number
    function automatic logic [15:0] m_addr(input ppu_regs_t r, input int kind, input int fx,
                                           input logic [7:0] tn);
        int y;
        int a;
        y = (int'(r.ly) + int'(r.scy)) % 256;
        if (kind == 0) begin
            a = (r.lcdc[3] ? 'h9C00 : 'h9800) + 32 * (y / 8) + ((int'(r.scx) / 8 + fx) % MAP_W);
        end else begin
            if (r.lcdc[4]) a = 'h8000 + 16 * int'(tn);
            else           a = 'h9000 + 16 * ((int'(tn) >= 128) ? int'(tn) - 256 : int'(tn));
            a = a + 2 * (y % 8) + ((kind == 2) ? 1 : 0);
        end
        return 16'(a);
    endfunction

    function automatic logic [15:0] m_pix(input logic bg_on, input logic [7:0] lo, input logic [7:0] hi);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) begin
            if (bg_on) p[2*i +: 2] = {hi[7-i], lo[7-i]};
        end
        return p;
    endfunction

    function automatic void expect_ev(input bit is_push, input logic [15:0] v);
        exp_t e;
        e.is_push = is_push;
        e.cyc     = cyc;
        e.val     = v;
        q.push_back(e);
    endfunction

    // Monitor: every read or push must match the next queued expectation
    always @(negedge clk) begin
        exp_t        e;
        logic [15:0] got_val;
        if (reset_n && (read_req || write_en)) begin
            n_checks++;
            got_val = write_en ? 16'(write_data) : addr;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_event: got read=%0d push=%0d val %h at dot %0d, expected none",
                         read_req, write_en, got_val, cyc);
            end else begin
                e = q.pop_front();
                if ((read_req && write_en) || (e.is_push != write_en) || (e.cyc != cyc) ||
                    (e.val !== got_val)) begin
                    n_fail++;
                    $display("FAIL event: got read=%0d push=%0d val %h dot %0d, expected push=%0d val %h dot %0d",
                             read_req, write_en, got_val, cyc, e.is_push, e.val, e.cyc);
                end
            end
        end
    end

    task automatic set_fifo(input bit ready);
        if (ready) begin
            empty = 1'b1;
            full  = 1'b0;
        end else begin
            case ($urandom_range(2))
                0:       begin empty = 1'b0; full = 1'b0; end
                1:       begin empty = 1'b0; full = 1'b1; end
                default: begin empty = 1'b1; full = 1'b1; end
            endcase
        end
    endtask

    task automatic mid_reset();
        reset_n = 1'b0;
        active  = 1'b0;
        #1;
        check("rst_read_req", 32'(read_req), 0);
        check("rst_write_en", 32'(write_en), 0);
        check("rst_addr", 32'(addr), 0);
        check("rst_write_data", 32'(16'(write_data)), 0);
`ifdef PPU_FETCH_PERF_EN
        check("rst_stall", 32'(stall_cycles), 0);
`endif
        q.delete();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    // One active window: n_tiles tiles, optional abort/reset at dot rel after
    // the rising dot, optional fixed stall_n dots of empty=0 at each push.
    task automatic run(input int n_tiles, input int abort_rel, input int reset_rel,
                       input int stall_n, input int ready_pct, input bit vary);
        int          rel;
        int          c;
        bit          done;
        bit          ready;
        logic [7:0]  tn;
        logic [7:0]  lo;
        logic [7:0]  hi;
        logic [15:0] a;
        @(posedge clk);
        #1;
        active = 1'b1;
        set_fifo(1'b1);
        rel  = 0;
        done = 0;
        tn = '0; lo = '0; hi = '0;
        for (int k = 0; k < n_tiles && !done; k++) begin
            c = 0;
            while (!done) begin
                @(posedge clk);
                #1;
                rel++;
                if (rel == abort_rel) begin
                    active = 1'b0;
                    done   = 1;
                end else if (rel == reset_rel) begin
                    mid_reset();
                    done = 1;
                end else begin
                    if (vary && $urandom_range(9) == 0) begin
                        regs.scx = 8'($urandom);
                        regs.scy = 8'($urandom);
                        regs.ly  = 8'($urandom);
                    end
                    if (c >= 6) begin
                        if (stall_n >= 0) begin
                            empty = (c - 6 >= stall_n);
                            full  = 1'b0;
                        end else begin
                            ready = ($urandom_range(99) < ready_pct);
                            set_fifo(ready);
                        end
                    end else begin
                        empty = 1'($urandom_range(1));
                        full  = 1'($urandom_range(1));
                    end
                    if (c == 0) begin
                        a  = m_addr(regs, 0, k, 8'h00);
                        tn = vram[a];
                        expect_ev(1'b0, a);
                    end else if (c == 2) begin
                        a  = m_addr(regs, 1, k, tn);
                        lo = vram[a];
                        expect_ev(1'b0, a);
                    end else if (c == 4) begin
                        a  = m_addr(regs, 2, k, tn);
                        hi = vram[a];
                        expect_ev(1'b0, a);
                    end
                    if (c >= 6 && empty && !full) begin
                        expect_ev(1'b1, m_pix(regs.lcdc[0], lo, hi));
                        break;
                    end
                    c++;
                end
            end
        end
        if (!done) begin
            @(posedge clk);
            #1;
            active = 1'b0;
        end
    endtask

    task automatic idle_check(input int n);
        repeat (n) begin
            @(negedge clk);
            check("idle_quiet", 32'({read_req, write_en}), 0);
        end
        check("queue_drained", 32'(q.size()), 0);
    endtask

    task automatic set_regs(input logic [7:0] lcdc, input logic [7:0] scx,
                            input logic [7:0] scy, input logic [7:0] ly);
        regs.lcdc = lcdc;
        regs.scx  = scx;
        regs.scy  = scy;
        regs.ly   = ly;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset_n  = 1'b0;
        active   = 1'b0;
        empty    = 1'b1;
        full     = 1'b0;
        set_regs(8'h91, 8'h00, 8'h00, 8'h00);
        for (int i = 0; i < 65536; i++) vram[i] = 8'($urandom);
        vram[16'h9800] = 8'h01;
        vram[16'h8010] = 8'hF0;
        vram[16'h8011] = 8'hCC;

        #7;
        check("reset_read_req", 32'(read_req), 0);
        check("reset_write_en", 32'(write_en), 0);
        check("reset_addr", 32'(addr), 0);
        check("reset_write_data", 32'(16'(write_data)), 0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        idle_check(2);

        // Basic tile: 0x9800, 0x8010, 0x8011, push 7 dots after active rises
        run(1, -1, -1, -1, 100, 0);
        idle_check(3);

        // Signed tile indexing with fine-y 3
        set_regs(8'h81, 8'h00, 8'h00, 8'h03);
        vram[16'h9800] = 8'h80;
        run(1, -1, -1, -1, 100, 0);
        idle_check(2);
        vram[16'h9800] = 8'h01;

        // Map column wrap and vertical scroll wrap
        set_regs(8'h91, 8'hF8, 8'hFF, 8'h02);
        run(2, -1, -1, -1, 100, 0);
        idle_check(2);

        // Five dots of empty=0 at PUSH
        set_regs(8'h91, 8'h00, 8'h00, 8'h00);
        run(1, -1, -1, 5, 100, 0);
`ifdef PPU_FETCH_PERF_EN
        check("stall_cycles_5", 32'(stall_cycles), 5);
`endif
        idle_check(2);

        // BG disabled: same fetch timing, zero pixels
        set_regs(8'h90, 8'h10, 8'h00, 8'h00);
        run(2, -1, -1, -1, 100, 0);
        idle_check(2);

        // Abort during DATA_HI, then restart from column 0
        set_regs(8'h91, 8'h10, 8'h00, 8'h00);
        run(3, 5, -1, -1, 100, 0);
        idle_check(3);
        run(1, -1, -1, -1, 100, 0);
        idle_check(2);

        // Reset pulse in DATA_LO, then the first scenario again
        set_regs(8'h91, 8'h00, 8'h00, 8'h00);
        run(1, -1, 4, -1, 100, 0);
        idle_check(2);
        run(1, -1, -1, -1, 100, 0);
        idle_check(2);

        // Randomized windows
        for (int r = 0; r < 40; r++) begin
            int nt;
            int ab;
            set_regs(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
            nt = $urandom_range(6, 1);
            ab = ($urandom_range(3) == 0) ? $urandom_range(nt * 8, 1) : -1;
            run(nt, ab, -1, -1, $urandom_range(100, 30), 1);
            idle_check(2);
        end

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule

// File: doc/bg_fetcher.md
BG_FETCHER -- requirements
Module: bg_fetcher

Interface
REQ-001 SHALL have parameter MAP_WIDTH_TILES, default 32, tile columns per BG map row; the fetch column counter wraps modulo this.
REQ-002 SHALL have port clk  input  1  PPU clock, one dot per rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port active  input  1  high while the PPU is in the pixel-transfer mode.
REQ-005 SHALL have port regs  input  ppu_regs_t  register file; uses lcdc, scx, scy, ly.
REQ-006 SHALL have port read_req  output  1  VRAM read request.
REQ-007 SHALL have port addr  output  16  VRAM byte address.
REQ-008 SHALL have port rdata  input  8  VRAM data, valid the cycle after read_req.
REQ-009 SHALL have port write_en  output  1  one-cycle push of 8 pixels to the pixel FIFO.
REQ-010 SHALL have port write_data  output  gb_color_t[FIFO_DEPTH]  pixels; index 0 is the leftmost pixel.
REQ-011 SHALL have ports full and empty  input  1 each  pixel FIFO status.

Function
REQ-012 SHALL use FSM states IDLE, TILE_NUM, DATA_LO, DATA_HI, PUSH.
REQ-013 SHALL hold IDLE with fetch_x = 0 while active is 0.
REQ-014 SHALL leave IDLE for TILE_NUM on the first cycle active is 1.
REQ-015 TILE_NUM, DATA_LO and DATA_HI SHALL each last 2 cycles.
REQ-016 Within each 2-cycle state, cycle 1 SHALL assert read_req with addr; cycle 2 SHALL latch rdata into tile_num, lo or hi.
REQ-017 Map address SHALL be: base (lcdc[3] ? 0x9C00 : 0x9800) + 32 * (((ly + scy) mod 256) >> 3) + (((scx >> 3) + fetch_x) mod MAP_WIDTH_TILES).
REQ-018 Data address for lcdc[4] = 1 SHALL be 0x8000 + 16 * tile_num (unsigned).
REQ-019 Data address for lcdc[4] = 0 SHALL be 0x9000 + 16 * signed(tile_num).
REQ-020 Each data address SHALL add 2 * ((ly + scy) mod 8), plus 1 for DATA_HI; all arithmetic is 16-bit and wraps.
REQ-021 PUSH SHALL assert write_en for exactly one cycle, only when empty = 1 and full = 0; otherwise it waits in PUSH.
REQ-022 Pushed pixels SHALL be write_data[i] = {hi[7-i], lo[7-i]}.
REQ-023 When lcdc[0] = 0, all pushed pixels SHALL be 0 and fetch timing SHALL be unchanged.
REQ-024 After a push, fetch_x SHALL increment (wrapping) and the state SHALL return to TILE_NUM.
REQ-025 Minimum tile period SHALL be 7 cycles.
REQ-026 active falling in any state SHALL force IDLE next cycle, with read_req and write_en low that cycle and no partial push.
REQ-027 read_req and write_en SHALL never be high in the same cycle.
REQ-028 Registers SHALL be sampled combinationally each cycle; a mid-tile scx/scy change affects only subsequent address computations.

Reset
REQ-029 reset_n low SHALL immediately force IDLE with fetch_x, tile_num, lo, hi = 0.
REQ-030 During reset, read_req = 0, write_en = 0, addr = 0x0000 and write_data all 0.
REQ-031 Reset asserted mid-fetch SHALL discard the fetch; after release, behaviour SHALL equal a fresh start.

Configuration
REQ-032 Macro PPU_FETCH_PERF_EN defined SHALL add output stall_cycles (16 bits).
REQ-033 stall_cycles SHALL count cycles spent in PUSH without a push, saturate at 0xFFFF, and clear on reset and on active rising.
REQ-034 With PPU_FETCH_PERF_EN undefined, the port and counter SHALL be absent and all other behaviour identical.

Structure
REQ-035 The fetcher state enum, map base constants (0x9800, 0x9C00) and tile data bases (0x8000, 0x9000) SHALL live in ppu_types_pkg.
REQ-036 gb_color_t and FIFO_DEPTH SHALL be taken from ppu_types_pkg.
REQ-037 The pure address function SHALL live in ppu_util_pkg.
REQ-038 There SHALL be no sub-module; the block is a single FSM.

Verification
REQ-039 Scenario: lcdc = 0x91, scx = scy = ly = 0, map[0x9800] = 0x01, VRAM 0x8010/0x8011 = 0xF0/0xCC, FIFO empty -> addrs 0x9800, 0x8010, 0x8011; write_en at cycle 7; write_data = {3,3,1,1,2,2,0,0}.
REQ-040 Scenario: lcdc[4] = 0, tile_num = 0x80, ly = 3 -> lo addr 0x8806, hi addr 0x8807.
REQ-041 Scenario: scx = 0xF8, second tile -> map column wraps to 0; scy = 0xFF, ly = 2 -> map row 0, fine-y 1.
REQ-042 Scenario: empty held 0 for 5 cycles at PUSH -> write_en delayed exactly 5 cycles; stall_cycles = 5 when the macro is defined.
REQ-043 Scenario: active dropped during DATA_HI -> IDLE next cycle, no write_en; re-raise -> fetch restarts at fetch_x = 0.
REQ-044 Scenario: reset_n pulsed low mid DATA_LO -> outputs 0 asynchronously; post-release trace equals the first scenario.
